// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding bus request, one-slot output register to decode,
// delay-slot branch redirect, flush with stale-response drop, and misaligned-PC exception slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq,
    output logic [31:0] iaddr,
    input  logic        iaddr_ok,
    input  logic        idata_ok,
    input  logic [31:0] idata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_adel
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;
    logic        drop_q, drop_d;
    logic        halt_q, halt_d;
    logic        ireq_q, ireq_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_adel_q, out_adel_d;

    logic        take_redirect;
    logic        advance;
    logic [31:0] pc_adv;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        pending_d     = pending_q;
        drop_d        = drop_q;
        halt_d        = halt_q;
        out_valid_d   = 1'b0;
        out_pc_d      = out_pc_q;
        out_instr_d   = out_instr_q;
        out_adel_d    = 1'b0;
        advance       = 1'b0;
        take_redirect = redirect && !stall;
        // A redirect arriving in the advance cycle itself applies directly.
        pc_adv        = take_redirect ? redirect_pc :
                        (pending_q ? target_q : pc_q + 32'd4);

        case (state_q)
            S_REQ: begin
                if (drop_q) begin
                    if (idata_ok) drop_d = 1'b0;
                end else if (!halt_q) begin
                    if (pc_q[1:0] != 2'b00) begin
                        out_valid_d = 1'b1;
                        out_adel_d  = 1'b1;
                        out_pc_d    = pc_q;
                        out_instr_d = '0;
                        halt_d      = 1'b1;
                        state_d     = stall ? S_HOLD : S_REQ;
                    end else if (ireq_q && iaddr_ok) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (idata_ok) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_instr_d = idata;
                    if (stall) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_REQ;
                        advance = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (stall) begin
                    out_valid_d = out_valid_q;
                    out_adel_d  = out_adel_q;
                end else begin
                    state_d = S_REQ;
                    advance = !halt_q;
                end
            end
            default: state_d = S_REQ;
        endcase

        if (advance) begin
            pc_d      = pc_adv;
            pending_d = 1'b0;
        end else if (take_redirect) begin
            pending_d = 1'b1;
            target_d  = redirect_pc;
        end

        // An accepted-but-unanswered request at flush time must have its response swallowed.
        if (flush) begin
            state_d     = S_REQ;
            pc_d        = flush_pc;
            pending_d   = 1'b0;
            halt_d      = 1'b0;
            out_valid_d = 1'b0;
            out_adel_d  = 1'b0;
            out_pc_d    = out_pc_q;
            out_instr_d = out_instr_q;
            drop_d      = ((state_q == S_WAIT) && !idata_ok) ||
                          ((state_q == S_REQ) && ireq_q && iaddr_ok) ||
                          (drop_q && !idata_ok);
        end

        ireq_d = (state_d == S_REQ) && !drop_d && !halt_d && (pc_d[1:0] == 2'b00);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            target_q    <= '0;
            pending_q   <= 1'b0;
            drop_q      <= 1'b0;
            halt_q      <= 1'b0;
            ireq_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_adel_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            halt_q      <= halt_d;
            ireq_q      <= ireq_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_adel_q  <= out_adel_d;
        end
    end

    assign ireq      = ireq_q;
    assign iaddr     = pc_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_adel  = out_adel_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL have: resetn  in  1  asynchronous active-low reset; one clock, no other clock domain.
REQ-003 SHALL have: ireq  out  1  instruction-bus request valid.
REQ-004 SHALL have: iaddr  out  32  instruction fetch address.
REQ-005 SHALL have: iaddr_ok  in  1  bus accepted address this cycle.
REQ-006 SHALL have: idata_ok  in  1  instruction data returned this cycle.
REQ-007 SHALL have: idata  in  32  returned instruction word.
REQ-008 SHALL have: stall  in  1  decode cannot accept (load-use hazard).
REQ-009 SHALL have: redirect  in  1  taken branch/jump resolved in decode.
REQ-010 SHALL have: redirect_pc  in  32  branch/jump target.
REQ-011 SHALL have: flush  in  1  exception/eret; discard all fetch state.
REQ-012 SHALL have: flush_pc  in  32  restart address on flush.
REQ-013 SHALL have: out_valid  out  1  / out_pc  out  32  / out_instr  out  32  / out_adel  out  1  -- slot presented to decode.
REQ-014 SHALL have parameter: RESET_PC, default 32'hBFC0_0000, first fetch address.

Function
REQ-015 SHALL implement FSM states REQ (drive ireq), WAIT (address accepted, awaiting data), HOLD (data captured, decode stalled).
REQ-016 SHALL in REQ drive ireq=1, iaddr=pc; on iaddr_ok move to WAIT; iaddr SHALL stay stable while ireq=1 and iaddr_ok=0.
REQ-017 SHALL at most one outstanding request; ireq=0 in WAIT and HOLD.
REQ-018 SHALL in WAIT on idata_ok capture idata into out_instr, pc into out_pc, assert out_valid next cycle; if stall=0 go to REQ with pc advanced, else HOLD.
REQ-019 SHALL in HOLD keep out_* constant while stall=1; on stall=0 deassert out_valid and go to REQ.
REQ-020 SHALL present each instruction to decode for exactly one cycle with stall=0 (no duplicate, no drop).
REQ-021 SHALL compute next pc as pc+4 (32-bit wrap, 32'hFFFF_FFFC+4=0) unless a redirect is pending.
REQ-022 SHALL on redirect=1 with stall=0 latch redirect_pc as pending target; the current in-flight/held instruction (delay slot) is still delivered, then the fetch after it uses the target, and the pending flag clears.
REQ-023 SHALL ignore redirect while stall=1 (decode re-asserts after stall clears).
REQ-024 SHALL on flush=1 (priority over redirect and stall) next cycle set pc=flush_pc, clear pending redirect, out_valid=0, state REQ.
REQ-025 SHALL, if flush occurs in WAIT, set a drop flag and discard the next idata_ok response without presenting it; no new ireq until that response arrives.
REQ-026 SHALL, if flush and idata_ok coincide in WAIT, discard that data and not set the drop flag.
REQ-027 SHALL on pc[1:0]!=0 issue no bus request, present out_valid=1, out_pc=pc, out_instr=0, out_adel=1 for one non-stalled cycle, then stop fetching until flush.
REQ-028 SHALL keep out_adel=0 for all aligned fetches.
REQ-029 SHALL be fully synchronous except resetn; no combinational path from idata to ireq/iaddr.

Reset
REQ-030 SHALL while resetn=0: pc=RESET_PC, state REQ, ireq=0, iaddr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, out_adel=0, pending and drop flags clear.
REQ-031 SHALL assert ireq with iaddr=RESET_PC in the first cycle after resetn deasserts.
REQ-032 SHALL, on reset during WAIT, forget the outstanding request entirely (bus assumed reset together).

Verification
REQ-033 Sequential fetch: zero-wait bus, idata 0x1,0x2,0x3 -> out_pc 0xBFC00000,0xBFC00004,0xBFC00008 with matching out_instr, one cycle each.
REQ-034 Stall: stall=1 for 3 cycles while out_pc=0xBFC00004 valid -> out_* held, ireq=0, then next out_pc 0xBFC00008 exactly once.
REQ-035 Branch: redirect=1, redirect_pc=0xBFC00100 while fetching 0xBFC00008 -> 0xBFC00008 delivered (delay slot), next iaddr 0xBFC00100.
REQ-036 Flush in WAIT: flush_pc=0xBFC00380 while request 0xBFC0000C outstanding -> that response dropped, next ireq iaddr=0xBFC00380, no out_valid for 0xBFC0000C.
REQ-037 Misaligned: redirect_pc=0xBFC00102 -> no ireq to it, out_valid=1, out_adel=1, out_pc=0xBFC00102, out_instr=0; fetch resumes at flush_pc after flush.
REQ-038 Async reset asserted mid-WAIT -> outputs reach REQ-030 values without a clock edge; first post-reset iaddr=0xBFC00000.
